// File: rtl/oppm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : oppm_pkg
// Brief   : Shared types and defaults for the OPPM TX/RX blocks.
// Revision: 1.0 - initial release
// ============================================================================
package oppm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

  localparam int N_PKT_DEF         = 8;
  localparam int GAP_CYCLES_DEF    = 16;
  localparam int START_TIMEOUT_DEF = 64;

  // Index width for n requesters, never below one bit.
  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Counter width able to hold the value n itself.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/oppm_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : oppm_tx_scheduler_if
// Brief   : Source request bus plus Encoder start/avail handshake.
// Revision: 1.0 - initial release
// ============================================================================
interface oppm_tx_scheduler_if
  import oppm_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int N_PKT   = N_PKT_DEF
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*N_PKT-1:0] req_data;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       err;
  logic [N_PKT-1:0]         enc_data;
  logic                     enc_start;
  logic                     enc_avail;

  modport master (
    input  req, req_data, enc_avail,
    output grant, done, err, enc_data, enc_start
  );

  modport slave (
    output req, req_data, enc_avail,
    input  grant, done, err, enc_data, enc_start
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick: rotate, find-first, rotate back.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  logic [N-1:0] rot;
  logic         found;
  int           ff;
  int           sum;

  always_comb begin
    rot   = N'({req_i, req_i} >> ptr_i);
    found = 1'b0;
    ff    = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        ff    = i;
      end
    end
    sum = ff + int'(ptr_i);
    if (sum >= N) sum = sum - N;
    idx_o   = PTR_W'(sum);
    gnt_o   = found ? (N'(1) << sum) : '0;
    valid_o = |req_i;
  end

endmodule
`default_nettype wire

// File: rtl/oppm_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : oppm_tx_scheduler
// Brief   : Round-robin scheduler sharing one OPPM Encoder among NUM_REQ sources.
// Revision: 1.0 - initial release
// ============================================================================
module oppm_tx_scheduler
  import oppm_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int N_PKT         = N_PKT_DEF,
  parameter int GAP_CYCLES    = GAP_CYCLES_DEF,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  oppm_tx_scheduler_if.master  bus,
  output logic                 busy
);

  localparam int PTR_W = ptr_w(NUM_REQ);
  localparam int GAP_W = cnt_w(GAP_CYCLES);
  localparam int TO_W  = cnt_w(START_TIMEOUT);

  localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(GAP_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(START_TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_REQ - 1);

  sched_state_t       state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [N_PKT-1:0]   enc_data_q, enc_data_d;
  logic               enc_start_q, enc_start_d;
  logic               busy_q, busy_d;
  logic               seen_q, seen_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   own_q, own_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TO_W-1:0]    to_q, to_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [N_PKT-1:0]   win_data;
  logic [PTR_W-1:0]   ptr_nxt;
  sched_state_t       after_pkt;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign win_data  = bus.req_data[int'(arb_idx)*N_PKT +: N_PKT];
  assign ptr_nxt   = (own_q == PTR_MAX) ? '0 : own_q + PTR_W'(1);
  assign after_pkt = (GAP_CYCLES == 0) ? IDLE : GAP;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    err_d       = '0;
    enc_data_d  = enc_data_q;
    enc_start_d = enc_start_q;
    seen_d      = seen_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    gap_d       = gap_q;
    to_d        = to_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d     = arb_gnt;
          own_d       = arb_idx;
          enc_data_d  = win_data;
          enc_start_d = 1'b1;
          seen_d      = 1'b0;
          to_d        = '0;
          state_d     = START;
        end
      end
      START: begin
        to_d = to_q + TO_W'(1);
        // Accept only a falling avail that followed a sampled start+avail cycle,
        // so an Encoder still finishing the previous packet is not mistaken for acceptance.
        if (!bus.enc_avail && seen_q) begin
          enc_start_d = 1'b0;
          state_d     = BUSY;
        end else if (to_q == TO_LAST) begin
          enc_start_d = 1'b0;
          grant_d     = '0;
          err_d       = grant_q;
          ptr_d       = ptr_nxt;
          gap_d       = GAP_LD;
          state_d     = after_pkt;
        end else if (bus.enc_avail) begin
          seen_d = 1'b1;
        end
      end
      BUSY: begin
        if (bus.enc_avail) begin
          grant_d = '0;
          done_d  = grant_q;
          ptr_d   = ptr_nxt;
          gap_d   = GAP_LD;
          state_d = after_pkt;
        end
      end
      GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
      enc_data_q  <= '0;
      enc_start_q <= 1'b0;
      busy_q      <= 1'b0;
      seen_q      <= 1'b0;
      ptr_q       <= '0;
      own_q       <= '0;
      gap_q       <= '0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      enc_data_q  <= enc_data_d;
      enc_start_q <= enc_start_d;
      busy_q      <= busy_d;
      seen_q      <= seen_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      gap_q       <= gap_d;
      to_q        <= to_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.enc_data  = enc_data_q;
  assign bus.enc_start = enc_start_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_oppm_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_oppm_tx_scheduler
// Brief   : Directed bench for oppm_tx_scheduler (GAP=16 and GAP=0 instances).
// Revision: 1.0 - initial release
// ============================================================================
module tb_oppm_tx_scheduler;
  import oppm_pkg::*;

  localparam int NR      = 4;
  localparam int NP      = 8;
  localparam int ENC_LEN = 4;
  localparam int EV_START = 0, EV_DONE = 1, EV_ERR = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oppm_tx_scheduler_if #(.NUM_REQ(NR), .N_PKT(NP)) bus0 ();
  oppm_tx_scheduler_if #(.NUM_REQ(NR), .N_PKT(NP)) bus1 ();
  logic busy0, busy1;

  oppm_tx_scheduler #(.NUM_REQ(NR), .N_PKT(NP), .GAP_CYCLES(16), .START_TIMEOUT(64)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0));
  oppm_tx_scheduler #(.NUM_REQ(NR), .N_PKT(NP), .GAP_CYCLES(0), .START_TIMEOUT(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1));

  // Encoder stubs: 0 = manual avail, 1 = auto (accepts after one sampled start), 2 = never accepts.
  int   mode0 = 0, mode1 = 1, cnt0 = 0, cnt1 = 0;
  bit   arm0 = 0, arm1 = 0;
  logic avail0 = 1'b1, avail1 = 1'b1, man_av0 = 1'b1;
  assign bus0.enc_avail = (mode0 == 0) ? man_av0 : avail0;
  assign bus1.enc_avail = avail1;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail0 = 1'b1; cnt0 = 0; arm0 = 0;
    end else if (mode0 == 2) avail0 = 1'b1;
    else if (mode0 == 1) begin
      if (cnt0 > 0) begin
        cnt0--;
        if (cnt0 == 0) avail0 = 1'b1;
      end else if (bus0.enc_start && avail0) begin
        if (arm0) begin avail0 = 1'b0; cnt0 = ENC_LEN; arm0 = 0; end
        else arm0 = 1;
      end
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail1 = 1'b1; cnt1 = 0; arm1 = 0;
    end else if (mode1 == 1) begin
      if (cnt1 > 0) begin
        cnt1--;
        if (cnt1 == 0) avail1 = 1'b1;
      end else if (bus1.enc_start && avail1) begin
        if (arm1) begin avail1 = 1'b0; cnt1 = ENC_LEN; arm1 = 0; end
        else arm1 = 1;
      end
    end
  end

  // Continuous invariant monitor; judged once at the end.
  int inv_viol = 0, done_cnt0 = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!$onehot0(bus0.grant) || !$onehot0(bus0.done) || !$onehot0(bus0.err) ||
          ((|bus0.done) && (|bus0.err)) || (bus0.enc_start && !$onehot(bus0.grant)))
        inv_viol++;
      if (!$onehot0(bus1.grant) || !$onehot0(bus1.done) || !$onehot0(bus1.err) ||
          ((|bus1.done) && (|bus1.err)) || (bus1.enc_start && !$onehot(bus1.grant)))
        inv_viol++;
      if (|bus0.done) done_cnt0++;
    end
  end

  int errs = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit ev(input int d, input int k);
    if (k == EV_START) return (d == 0) ? bus0.enc_start : bus1.enc_start;
    if (k == EV_DONE)  return (d == 0) ? |bus0.done : |bus1.done;
    return (d == 0) ? |bus0.err : |bus1.err;
  endfunction

  // Counts falling edges until the event is seen; -1 when the budget runs out.
  task automatic wait_ev(input int d, input int k, output int n);
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (ev(d, k)) begin n = i; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus0.req = '0; bus1.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        avail;
    int          n;
    logic [3:0]  grant;
    logic        start;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  edata;
  } vec_t;

  vec_t tbl[22];
  logic [7:0] rr_exp[5];
  int n;

  initial begin : main
    tbl[0]  = '{4'h0, 32'h0000_0000, 1'b1, 1,  4'h0, 1'b0, 4'h0, 1'b0, 8'h00};
    tbl[1]  = '{4'h1, 32'h0000_00A5, 1'b1, 1,  4'h1, 1'b1, 4'h0, 1'b1, 8'hA5};
    tbl[2]  = '{4'h1, 32'h0000_00A5, 1'b1, 1,  4'h1, 1'b1, 4'h0, 1'b1, 8'hA5};
    tbl[3]  = '{4'h1, 32'h0000_00A5, 1'b0, 1,  4'h1, 1'b0, 4'h0, 1'b1, 8'hA5};
    tbl[4]  = '{4'h1, 32'h0000_00A5, 1'b0, 1,  4'h1, 1'b0, 4'h0, 1'b1, 8'hA5};
    tbl[5]  = '{4'h1, 32'h0000_00A5, 1'b1, 1,  4'h0, 1'b0, 4'h1, 1'b1, 8'hA5};
    tbl[6]  = '{4'h0, 32'h0000_00A5, 1'b1, 1,  4'h0, 1'b0, 4'h0, 1'b1, 8'hA5};
    tbl[7]  = '{4'h0, 32'h0000_00A5, 1'b1, 14, 4'h0, 1'b0, 4'h0, 1'b1, 8'hA5};
    tbl[8]  = '{4'h0, 32'h0000_00A5, 1'b1, 1,  4'h0, 1'b0, 4'h0, 1'b0, 8'hA5};
    tbl[9]  = '{4'h2, 32'h0000_5C00, 1'b1, 1,  4'h2, 1'b1, 4'h0, 1'b1, 8'h5C};
    tbl[10] = '{4'h2, 32'h0000_5C00, 1'b1, 1,  4'h2, 1'b1, 4'h0, 1'b1, 8'h5C};
    tbl[11] = '{4'h2, 32'h0000_5C00, 1'b0, 1,  4'h2, 1'b0, 4'h0, 1'b1, 8'h5C};
    tbl[12] = '{4'h0, 32'h0000_FF00, 1'b0, 2,  4'h2, 1'b0, 4'h0, 1'b1, 8'h5C};
    tbl[13] = '{4'h0, 32'h0000_FF00, 1'b1, 1,  4'h0, 1'b0, 4'h2, 1'b1, 8'h5C};
    tbl[14] = '{4'h0, 32'h0000_FF00, 1'b1, 1,  4'h0, 1'b0, 4'h0, 1'b1, 8'h5C};
    tbl[15] = '{4'h0, 32'h0000_FF00, 1'b1, 15, 4'h0, 1'b0, 4'h0, 1'b0, 8'h5C};
    tbl[16] = '{4'h8, 32'h3C00_0000, 1'b0, 1,  4'h8, 1'b1, 4'h0, 1'b1, 8'h3C};
    tbl[17] = '{4'h8, 32'h3C00_0000, 1'b0, 3,  4'h8, 1'b1, 4'h0, 1'b1, 8'h3C};
    tbl[18] = '{4'h8, 32'h3C00_0000, 1'b1, 1,  4'h8, 1'b1, 4'h0, 1'b1, 8'h3C};
    tbl[19] = '{4'h8, 32'h3C00_0000, 1'b0, 1,  4'h8, 1'b0, 4'h0, 1'b1, 8'h3C};
    tbl[20] = '{4'h1, 32'h3C00_0077, 1'b1, 1,  4'h0, 1'b0, 4'h8, 1'b1, 8'h3C};
    tbl[21] = '{4'h1, 32'h3C00_0077, 1'b1, 1,  4'h0, 1'b0, 4'h0, 1'b1, 8'h3C};
    rr_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    bus0.req = '0; bus0.req_data = '0;
    bus1.req = '0; bus1.req_data = '0;

    @(posedge clk); #1;
    check("reset0", {bus0.grant, bus0.enc_start, bus0.done, bus0.err, busy0, bus0.enc_data}, 64'h0);
    check("reset1", {bus1.grant, bus1.enc_start, bus1.done, bus1.err, busy1, bus1.enc_data}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cycle-accurate vectors with a manually driven enc_avail.
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      bus0.req      = tbl[i].req;
      bus0.req_data = tbl[i].data;
      man_av0       = tbl[i].avail;
      repeat (tbl[i].n) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {bus0.grant, bus0.enc_start, bus0.done, bus0.err, busy0, bus0.enc_data},
            {tbl[i].grant, tbl[i].start, tbl[i].done, 4'h0, tbl[i].busy, tbl[i].edata});
    end

    // Round robin with all sources requesting.
    mode0 = 1;
    do_reset();
    bus0.req      = 4'hF;
    bus0.req_data = 32'h4433_2211;
    for (int k = 0; k < 5; k++) begin
      wait_ev(0, EV_START, n);
      check("rr_start_seen", 64'(n > 0), 64'd1);
      check("rr_grant", 64'(bus0.grant), 64'(4'b0001 << (k % 4)));
      check("rr_data", 64'(bus0.enc_data), 64'(rr_exp[k]));
      wait_ev(0, EV_DONE, n);
      check("rr_done", 64'(bus0.done), 64'(4'b0001 << (k % 4)));
    end
    bus0.req = '0;

    // Guard gap: GAP_CYCLES=16 instance, then GAP_CYCLES=0 instance.
    do_reset();
    bus0.req = 4'b0100;
    wait_ev(0, EV_START, n);
    wait_ev(0, EV_DONE, n);
    check("gap16_done", 64'(bus0.done), 64'h4);
    wait_ev(0, EV_START, n);
    check("gap16_cycles", 64'(n), 64'd17);
    check("gap16_grant", 64'(bus0.grant), 64'h4);
    bus0.req = '0;
    bus1.req = 4'b0100;
    wait_ev(1, EV_START, n);
    wait_ev(1, EV_DONE, n);
    check("gap0_done", 64'(bus1.done), 64'h4);
    wait_ev(1, EV_START, n);
    check("gap0_cycles", 64'(n), 64'd1);
    bus1.req = '0;

    // Start timeout with an Encoder that never accepts.
    do_reset();
    mode0         = 2;
    bus0.req      = 4'b1010;
    bus0.req_data = 32'hC300_5A00;
    wait_ev(0, EV_START, n);
    check("to_grant", 64'(bus0.grant), 64'h2);
    done_cnt0 = 0;
    wait_ev(0, EV_ERR, n);
    check("to_cycles", 64'(n), 64'd64);
    check("to_err", 64'(bus0.err), 64'h2);
    check("to_drop", {bus0.enc_start, bus0.grant}, 64'h0);
    check("to_no_done", 64'(done_cnt0), 64'd0);
    mode0    = 1;
    bus0.req = 4'b1000;
    wait_ev(0, EV_START, n);
    check("to_next_gap", 64'(n), 64'd17);
    check("to_next_grant", {bus0.grant, bus0.enc_data}, {52'h0, 4'h8, 8'hC3});

    // Asynchronous reset while the Encoder is busy.
    do_reset();
    bus0.req = 4'b1000;
    wait_ev(0, EV_START, n);
    for (int i = 0; i < 20 && bus0.enc_start; i++) @(negedge clk);
    check("rstb_busy_state", {bus0.grant, bus0.enc_start, busy0}, {58'h0, 4'h8, 1'b0, 1'b1});
    #3 rst_n = 1'b0;
    #1;
    check("rstb_async", {bus0.grant, bus0.enc_start, busy0, bus0.done}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstb_regrant", {bus0.grant, bus0.enc_start}, {59'h0, 4'h8, 1'b1});
    bus0.req = '0;
    repeat (4) @(negedge clk);

    check("invariant_violations", 64'(inv_viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

endmodule
`default_nettype wire
